// File: rtl/usb_ep_buf_arb.sv
// Round-robin arbiter sharing the USB EP buffer TX write / RX read ports between N_REQ requesters.
// Optional `USB_EP_BUF_ARB_PRIO_EN: requester 0 gets fixed absolute priority over the round-robin.
module usb_ep_buf_arb #(
   parameter int N_REQ = 2,
   parameter int EPDW  = 16,
   parameter int EPAW  = 11 - $clog2(EPDW/8)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_REQ-1:0]        req,
   input  logic [N_REQ-1:0]        req_we,
   input  logic [N_REQ*EPAW-1:0]   req_addr,
   input  logic [N_REQ*EPDW-1:0]   req_wdata,
   output logic [N_REQ-1:0]        ack,
   output logic [EPDW-1:0]         rdata,
   output logic [EPAW-1:0]         ep_tx_addr_0,
   output logic [EPDW-1:0]         ep_tx_data_0,
   output logic                    ep_tx_we_0,
   output logic [EPAW-1:0]         ep_rx_addr_0,
   output logic                    ep_rx_re_0,
   input  logic [EPDW-1:0]         ep_rx_data_1
);

   localparam int IW = 2;
`ifdef USB_EP_BUF_ARB_PRIO_EN
   localparam bit PRIO = 1'b1;
`else
   localparam bit PRIO = 1'b0;
`endif

   logic [N_REQ-1:0] pend_q, pend_d, ack_q, ack_d;
   logic [IW-1:0]    last_q, last_d;
   logic             tx_we_q, tx_we_d, rx_re_q, rx_re_d;
   logic [EPAW-1:0]  tx_addr_q, tx_addr_d, rx_addr_q, rx_addr_d;
   logic [EPDW-1:0]  tx_data_q, tx_data_d;
   // read-ack pipeline: stage 1 is the re cycle, stage 2 is the ack cycle
   logic             rd1_vld_q, rd1_vld_d, rd2_vld_q, rd2_vld_d;
   logic [IW-1:0]    rd1_idx_q, rd1_idx_d;

   logic [N_REQ-1:0] elig;
   logic [3:0]       elig4;
   logic             gnt_vld, g_we;
   logic [IW-1:0]    gnt_idx, cand;
   logic [EPAW-1:0]  g_addr;
   logic [EPDW-1:0]  g_wdata;
   int               t;

   always_comb begin
      elig    = req & ~pend_q;
      elig4   = '0;
      elig4[N_REQ-1:0] = elig;
      gnt_vld = 1'b0;
      gnt_idx = '0;
      cand    = '0;
      t       = 0;
      if (PRIO && elig[0]) begin
         gnt_vld = 1'b1;
      end
      // search starts one past the last winner; requester 0 is excluded when it has priority
      for (int k = 1; k <= N_REQ; k++) begin
         t = int'(last_q) + k;
         if (t >= N_REQ) t = t - N_REQ;
         cand = IW'(t);
         if (!gnt_vld && elig4[cand] && !(PRIO && cand == '0)) begin
            gnt_vld = 1'b1;
            gnt_idx = cand;
         end
      end

      g_we    = 1'b0;
      g_addr  = '0;
      g_wdata = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (gnt_idx == IW'(i)) begin
            g_we    = req_we[i];
            g_addr  = req_addr[i*EPAW +: EPAW];
            g_wdata = req_wdata[i*EPDW +: EPDW];
         end
      end

      last_d = last_q;
      if (gnt_vld && !(PRIO && gnt_idx == '0)) last_d = gnt_idx;

      for (int i = 0; i < N_REQ; i++) begin
         ack_d[i]  = (gnt_vld && g_we && gnt_idx == IW'(i)) ||
                     (rd1_vld_q && rd1_idx_q == IW'(i));
         pend_d[i] = (pend_q[i] && !ack_q[i]) || (gnt_vld && gnt_idx == IW'(i));
      end

      tx_we_d   = gnt_vld && g_we;
      tx_addr_d = tx_we_d ? g_addr  : tx_addr_q;
      tx_data_d = tx_we_d ? g_wdata : tx_data_q;
      rx_re_d   = gnt_vld && !g_we;
      rx_addr_d = rx_re_d ? g_addr  : rx_addr_q;
      rd1_vld_d = rx_re_d;
      rd1_idx_d = gnt_idx;
      rd2_vld_d = rd1_vld_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_q    <= '0;
         ack_q     <= '0;
         last_q    <= IW'(N_REQ-1);
         tx_we_q   <= 1'b0;
         tx_addr_q <= '0;
         tx_data_q <= '0;
         rx_re_q   <= 1'b0;
         rx_addr_q <= '0;
         rd1_vld_q <= 1'b0;
         rd1_idx_q <= '0;
         rd2_vld_q <= 1'b0;
      end else begin
         pend_q    <= pend_d;
         ack_q     <= ack_d;
         last_q    <= last_d;
         tx_we_q   <= tx_we_d;
         tx_addr_q <= tx_addr_d;
         tx_data_q <= tx_data_d;
         rx_re_q   <= rx_re_d;
         rx_addr_q <= rx_addr_d;
         rd1_vld_q <= rd1_vld_d;
         rd1_idx_q <= rd1_idx_d;
         rd2_vld_q <= rd2_vld_d;
      end
   end

   assign ack          = ack_q;
   assign rdata        = rd2_vld_q ? ep_rx_data_1 : '0;
   assign ep_tx_we_0   = tx_we_q;
   assign ep_tx_addr_0 = tx_addr_q;
   assign ep_tx_data_0 = tx_data_q;
   assign ep_rx_re_0   = rx_re_q;
   assign ep_rx_addr_0 = rx_addr_q;

endmodule

// File: tb/tb_usb_ep_buf_arb.sv
// Scoreboard bench for usb_ep_buf_arb: random requesters, spec-level grant model, per-cycle expected outputs.
module tb_usb_ep_buf_arb;
   localparam int N = 4, DW = 16, AW = 10;
`ifdef USB_EP_BUF_ARB_PRIO_EN
   localparam bit PRIO = 1'b1;
`else
   localparam bit PRIO = 1'b0;
`endif

   logic clk = 1'b0, rst = 1'b1;
   always #5 clk = ~clk;

   logic [N-1:0]    req, req_we, ack;
   logic [N*AW-1:0] req_addr;
   logic [N*DW-1:0] req_wdata;
   logic [DW-1:0]   rdata, ep_tx_data_0;
   logic [DW-1:0]   ep_rx_data_1 = '0;
   logic [AW-1:0]   ep_tx_addr_0, ep_rx_addr_0;
   logic            ep_tx_we_0, ep_rx_re_0;

   usb_ep_buf_arb #(.N_REQ(N), .EPDW(DW), .EPAW(AW)) dut (
      .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_addr(req_addr),
      .req_wdata(req_wdata), .ack(ack), .rdata(rdata), .ep_tx_addr_0(ep_tx_addr_0),
      .ep_tx_data_0(ep_tx_data_0), .ep_tx_we_0(ep_tx_we_0), .ep_rx_addr_0(ep_rx_addr_0),
      .ep_rx_re_0(ep_rx_re_0), .ep_rx_data_1(ep_rx_data_1));

   // RX buffer contents are a fixed function of the address
   function automatic logic [DW-1:0] rx_word(input logic [AW-1:0] a);
      if (a == 10'h3FF) return 16'h5A5A;
      return {a[5:0], a} ^ 16'hC3A5;
   endfunction
   always @(posedge clk) if (ep_rx_re_0) ep_rx_data_1 <= rx_word(ep_rx_addr_0);

   typedef struct {
      logic [N-1:0]  ack;
      logic [DW-1:0] rdata;
      bit            we;
      logic [AW-1:0] waddr;
      logic [DW-1:0] wdata;
      bit            re;
      logic [AW-1:0] raddr;
   } exp_t;
   exp_t exp_q[int];

   int n_chk = 0, n_fail = 0, cyc = 0;
   bit mon_en = 0;
   logic [AW-1:0] h_waddr = '0, h_raddr = '0;
   logic [DW-1:0] h_wdata = '0;

   function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d actual=%h expected=%h", nm, cyc, act, exp);
      end
   endfunction

   always @(negedge clk) if (mon_en) begin
      exp_t e;
      e = '{default: 0};
      if (exp_q.exists(cyc)) begin
         e = exp_q[cyc];
         exp_q.delete(cyc);
      end
      if (e.we) begin h_waddr = e.waddr; h_wdata = e.wdata; end
      if (e.re) h_raddr = e.raddr;
      chk("ack", ack, e.ack);
      chk("rdata", rdata, e.rdata);
      chk("tx_we", ep_tx_we_0, e.we);
      chk("rx_re", ep_rx_re_0, e.re);
      chk("tx_addr", ep_tx_addr_0, h_waddr);
      chk("tx_data", ep_tx_data_0, h_wdata);
      chk("rx_addr", ep_rx_addr_0, h_raddr);
   end

   // requester behaviour and spec-level model state
   bit            rq[N], done[N];
   int            busy[N];              // cycle of the ack of the last granted access
   logic          we_r[N];
   logic [AW-1:0] ad_r[N];
   logic [DW-1:0] wd_r[N];
   int            p_req[N], p_we[N], fx_addr[N], fx_data[N];
   int            last = N-1;

   task automatic cfg(int i, int pr, int pw, int fa, int fd);
      p_req[i] = pr; p_we[i] = pw; fx_addr[i] = fa; fx_data[i] = fd;
   endtask

   task automatic new_access(int i);
      we_r[i] = ($urandom_range(99) < p_we[i]);
      ad_r[i] = (fx_addr[i] >= 0) ? AW'(fx_addr[i]) : AW'($urandom);
      wd_r[i] = (fx_data[i] >= 0) ? DW'(fx_data[i]) : DW'($urandom);
      done[i] = 0;
   endtask

   task automatic add_exp(int c);
      if (!exp_q.exists(c)) exp_q[c] = '{default: 0};
   endtask

   task automatic step();
      int g;
      @(posedge clk); #1; cyc++;
      for (int i = 0; i < N; i++) begin
         if (rq[i]) begin
            if (done[i] && cyc > busy[i]) begin
               if ($urandom_range(99) < p_req[i]) new_access(i); else rq[i] = 0;
            end else if (done[i]) begin
               // already sampled: changing fields must not affect the access in flight
               we_r[i] = 1'($urandom); ad_r[i] = AW'($urandom); wd_r[i] = DW'($urandom);
            end
         end else if ($urandom_range(99) < p_req[i]) begin
            rq[i] = 1; new_access(i);
         end
         req[i] = rq[i]; req_we[i] = we_r[i];
         req_addr[i*AW +: AW] = ad_r[i]; req_wdata[i*DW +: DW] = wd_r[i];
      end
      g = -1;
      if (PRIO && rq[0] && cyc > busy[0]) g = 0;
      for (int k = 1; k <= N; k++) begin
         int i;
         i = (last + k) % N;
         if (g < 0 && rq[i] && cyc > busy[i] && !(PRIO && i == 0)) g = i;
      end
      if (g >= 0) begin
         done[g] = 1;
         if (!(PRIO && g == 0)) last = g;
         add_exp(cyc+1);
         if (we_r[g]) begin
            busy[g] = cyc + 1;
            exp_q[cyc+1].we = 1; exp_q[cyc+1].waddr = ad_r[g]; exp_q[cyc+1].wdata = wd_r[g];
            exp_q[cyc+1].ack[g] = 1'b1;
         end else begin
            busy[g] = cyc + 2;
            exp_q[cyc+1].re = 1; exp_q[cyc+1].raddr = ad_r[g];
            add_exp(cyc+2);
            exp_q[cyc+2].ack[g] = 1'b1; exp_q[cyc+2].rdata = rx_word(ad_r[g]);
         end
      end
   endtask

   task automatic run(int n);
      for (int c = 0; c < n; c++) step();
   endtask

   task automatic idle_all();
      for (int i = 0; i < N; i++) cfg(i, 0, 0, -1, -1);
      run(8);
   endtask

   initial begin
      req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
      for (int i = 0; i < N; i++) begin
         rq[i] = 0; done[i] = 0; busy[i] = -10; we_r[i] = 0; ad_r[i] = '0; wd_r[i] = '0;
         cfg(i, 0, 0, -1, -1);
      end
      #2;
      chk("rst_ack", ack, 0);            chk("rst_rdata", rdata, 0);
      chk("rst_tx_we", ep_tx_we_0, 0);   chk("rst_rx_re", ep_rx_re_0, 0);
      chk("rst_tx_addr", ep_tx_addr_0, 0); chk("rst_rx_addr", ep_rx_addr_0, 0);
      chk("rst_tx_data", ep_tx_data_0, 0);
      @(posedge clk); #1; rst = 0; mon_en = 1;

      // requester 0 single write 0x012 <- 0xBEEF
      cfg(0, 100, 100, 'h012, 'hBEEF); step(); cfg(0, 0, 0, -1, -1); idle_all();
      // requester 1 single read of 0x3FF
      cfg(1, 100, 0, 'h3FF, -1); step(); cfg(1, 0, 0, -1, -1); idle_all();
      // full read contention
      for (int i = 0; i < N; i++) cfg(i, 100, 0, -1, -1);
      run(40); idle_all();
      // continuous reader 0 against continuous writer 1
      cfg(0, 100, 0, -1, -1); cfg(1, 100, 100, -1, -1);
      run(40); idle_all();
      // random mixes
      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < N; i++) cfg(i, $urandom_range(90, 20), $urandom_range(100), -1, -1);
         run(250); idle_all();
      end

      // reset while a read sits between re and ack
      cfg(1, 100, 0, 'h155, -1); step(); cfg(1, 0, 0, -1, -1);
      @(posedge clk); #1; cyc++;
      chk("re_before_rst", ep_rx_re_0, 1);
      rst = 1;
      exp_q.delete();
      h_waddr = '0; h_raddr = '0; h_wdata = '0;
      last = N-1; req = '0;
      for (int i = 0; i < N; i++) begin rq[i] = 0; done[i] = 0; busy[i] = -10; end
      @(posedge clk); #1; cyc++; rst = 0;
      run(3);
      for (int i = 0; i < N; i++) cfg(i, 100, 50, -1, -1);
      run(30); idle_all();

      chk("scoreboard_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
